// File: rtl/combo_meter_fx.sv
// Combo meter: clamped thermometer bar with max-combo sweep and break drain; optional blink via COMBO_METER_BLINK_EN.
// Latency 1 cycle combo->led in BAR; no backpressure, combo is sampled every clk edge.
module combo_meter_fx #(
  parameter int N_LEDS      = 16,
  parameter int CW          = 5,
  parameter int MAX_COMBO   = 16,
  parameter int STEP_CYCLES = 2500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW-1:0]     combo,
  output logic [N_LEDS-1:0] led,
  output logic              busy
);

  localparam int LW = $clog2(N_LEDS + 1);
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0] TICK_AT = SW'(STEP_CYCLES - 1);
  localparam logic [LW-1:0] FULL    = LW'(N_LEDS);

  typedef enum logic [1:0] {BAR, SWEEP, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [LW-1:0]     lit, lit_nxt, pos, pos_nxt, target;
  logic [CW-1:0]     prev_combo;
  logic [SW-1:0]     cnt, cnt_nxt;
  logic [N_LEDS-1:0] led_nxt;
  logic              tick, rise, brk;

  function automatic logic [N_LEDS-1:0] thermo(input logic [LW-1:0] k);
    logic [N_LEDS-1:0] t;
    t = '0;
    for (int i = 0; i < N_LEDS; i++) t[i] = (i < int'(k));
    return t;
  endfunction

  always_comb begin
    target = FULL;
    if (int'(combo) < N_LEDS) target = LW'(combo);
  end

  assign tick = (cnt == TICK_AT);
  assign rise = (int'(combo) >= MAX_COMBO) && (int'(prev_combo) < MAX_COMBO);
  assign brk  = (combo == '0) && (prev_combo != '0);

  always_comb begin
    state_nxt = state;
    lit_nxt   = lit;
    pos_nxt   = pos;
    case (state)
      BAR: begin
        lit_nxt = target;
        if (rise) begin
          state_nxt = SWEEP;
          pos_nxt   = '0;
          lit_nxt   = '0;
        end else if (brk) begin
          state_nxt = DRAIN;
          lit_nxt   = lit;
        end
      end
      SWEEP: begin
        lit_nxt = pos;
        if (combo == '0) begin
          state_nxt = DRAIN;
        end else if (tick) begin
          // Full bar is held for one extra step before handing back to BAR.
          if (pos == FULL) begin
            state_nxt = BAR;
            lit_nxt   = target;
          end else begin
            pos_nxt = pos + LW'(1);
            lit_nxt = pos + LW'(1);
          end
        end
      end
      DRAIN: begin
        if (rise) begin
          state_nxt = SWEEP;
          pos_nxt   = '0;
          lit_nxt   = '0;
        end else if (target >= lit) begin
          state_nxt = BAR;
          lit_nxt   = target;
        end else if (tick) begin
          lit_nxt = lit - LW'(1);
          if (lit - LW'(1) == target) state_nxt = BAR;
        end
      end
      default: state_nxt = BAR;
    endcase
  end

  // Step counter only runs inside an animation and restarts on every state entry.
  always_comb begin
    cnt_nxt = cnt + SW'(1);
    if (state_nxt != state || state_nxt == BAR || tick) cnt_nxt = '0;
  end

`ifdef COMBO_METER_BLINK_EN
  localparam int BLINK_LEN = 8 * STEP_CYCLES;
  localparam int BW        = $clog2(BLINK_LEN);
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          full_bar;

  assign full_bar = (state_nxt == BAR) && (lit_nxt == FULL);

  always_comb begin
    blink_cnt_nxt = blink_cnt + BW'(1);
    if (!full_bar || blink_cnt == BW'(BLINK_LEN - 1)) blink_cnt_nxt = '0;
    led_nxt = thermo(lit_nxt);
    if (full_bar && blink_cnt >= BW'(4 * STEP_CYCLES)) led_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) blink_cnt <= '0;
    else     blink_cnt <= blink_cnt_nxt;
  end
`else
  always_comb led_nxt = thermo(lit_nxt);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BAR;
      lit        <= '0;
      pos        <= '0;
      prev_combo <= '0;
      cnt        <= '0;
      led        <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      lit        <= lit_nxt;
      pos        <= pos_nxt;
      prev_combo <= combo;
      cnt        <= cnt_nxt;
      led        <= led_nxt;
      busy       <= (state_nxt != BAR);
    end
  end

endmodule

// File: tb/tb_combo_meter_fx.sv
// Directed bench for combo_meter_fx with STEP_CYCLES=4; each task checks its own scenario inline.
module tb_combo_meter_fx;

  logic        clk;
  logic        rst;
  logic [4:0]  combo;
  logic [15:0] led;
  logic        busy;
  int          total = 0;
  int          bad   = 0;

  combo_meter_fx #(.STEP_CYCLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .combo (combo),
    .led   (led),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] bar(input int k);
    logic [31:0] v;
    v = (32'd1 << k) - 32'd1;
    return v[15:0];
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; combo = 5'd0;
    step(2);
    total++; if (led !== 16'h0000) begin bad++; $display("FAIL reset_led got=%h want=0000", led); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0; combo = 5'd5;
    step(1);
    total++; if (led !== 16'h001F) begin bad++; $display("FAIL bar5 got=%h want=001F", led); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bar5_busy got=%b want=0", busy); end
    combo = 5'd3;
    step(1);
    total++; if (led !== 16'h0007) begin bad++; $display("FAIL bar3 got=%h want=0007", led); end
    combo = 5'd7;
    #2;
    total++; if (led !== 16'h0007) begin bad++; $display("FAIL latency_hold got=%h want=0007", led); end
    step(1);
    total++; if (led !== 16'h007F) begin bad++; $display("FAIL bar7 got=%h want=007F", led); end
  endtask

  task automatic test_sweep;
    combo = 5'd15;
    step(1);
    total++; if (led !== 16'h7FFF || busy !== 1'b0) begin bad++; $display("FAIL bar15 got=%h/%b want=7FFF/0", led, busy); end
    combo = 5'd16;
    for (int i = 0; i < 68; i++) begin
      step(1);
      total++;
      if (led !== bar(i / 4) || busy !== 1'b1) begin
        bad++; $display("FAIL sweep_cyc%0d got=%h/%b want=%h/1", i, led, busy, bar(i / 4));
      end
    end
    step(1);
    total++; if (led !== 16'hFFFF || busy !== 1'b0) begin bad++; $display("FAIL sweep_end got=%h/%b want=FFFF/0", led, busy); end
  endtask

  task automatic test_clamp;
    combo = 5'd17;
    step(1);
    total++; if (led !== 16'hFFFF || busy !== 1'b0) begin bad++; $display("FAIL clamp17 got=%h/%b want=FFFF/0", led, busy); end
    combo = 5'd31;
    for (int i = 0; i < 12; i++) begin
      step(1);
      total++;
      if (led !== 16'hFFFF || busy !== 1'b0) begin
        bad++; $display("FAIL clamp31_cyc%0d got=%h/%b want=FFFF/0", i, led, busy);
      end
    end
  endtask

  task automatic test_drain;
    combo = 5'd12;
    step(1);
    total++; if (led !== 16'h0FFF || busy !== 1'b0) begin bad++; $display("FAIL drop12 got=%h/%b want=0FFF/0", led, busy); end
    combo = 5'd0;
    for (int i = 0; i < 48; i++) begin
      step(1);
      total++;
      if (led !== bar(12 - i / 4) || busy !== 1'b1) begin
        bad++; $display("FAIL drain_cyc%0d got=%h/%b want=%h/1", i, led, busy, bar(12 - i / 4));
      end
    end
    step(1);
    total++; if (led !== 16'h0000 || busy !== 1'b0) begin bad++; $display("FAIL drain_end got=%h/%b want=0000/0", led, busy); end
  endtask

  task automatic test_abort_drain;
    combo = 5'd12;
    step(1);
    combo = 5'd0;
    step(25);
    total++; if (led !== 16'h003F || busy !== 1'b1) begin bad++; $display("FAIL drain_at6 got=%h/%b want=003F/1", led, busy); end
    combo = 5'd9;
    step(1);
    total++; if (led !== 16'h01FF || busy !== 1'b0) begin bad++; $display("FAIL resume9 got=%h/%b want=01FF/0", led, busy); end
  endtask

  task automatic test_abort_sweep;
    combo = 5'd16;
    step(41);
    total++; if (led !== 16'h03FF || busy !== 1'b1) begin bad++; $display("FAIL sweep_pos10 got=%h/%b want=03FF/1", led, busy); end
    combo = 5'd0;
    step(1);
    total++; if (led !== 16'h03FF || busy !== 1'b1) begin bad++; $display("FAIL abort_entry got=%h/%b want=03FF/1", led, busy); end
    step(3);
    total++; if (led !== 16'h03FF) begin bad++; $display("FAIL abort_hold got=%h want=03FF", led); end
    step(1);
    total++; if (led !== 16'h01FF || busy !== 1'b1) begin bad++; $display("FAIL abort_step1 got=%h/%b want=01FF/1", led, busy); end
    step(36);
    total++; if (led !== 16'h0000 || busy !== 1'b0) begin bad++; $display("FAIL abort_done got=%h/%b want=0000/0", led, busy); end
  endtask

  task automatic test_reset_mid_sweep;
    combo = 5'd16;
    step(29);
    total++; if (led !== 16'h007F || busy !== 1'b1) begin bad++; $display("FAIL sweep_pos7 got=%h/%b want=007F/1", led, busy); end
    rst = 1'b1;
    step(1);
    total++; if (led !== 16'h0000 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid got=%h/%b want=0000/0", led, busy); end
    step(1);
    total++; if (led !== 16'h0000 || busy !== 1'b0) begin bad++; $display("FAIL rst_hold got=%h/%b want=0000/0", led, busy); end
    rst = 1'b0;
    step(1);
    total++; if (led !== 16'h0000 || busy !== 1'b1) begin bad++; $display("FAIL resweep_start got=%h/%b want=0000/1", led, busy); end
    step(4);
    total++; if (led !== 16'h0001 || busy !== 1'b1) begin bad++; $display("FAIL resweep_pos1 got=%h/%b want=0001/1", led, busy); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_clamp();
    test_drain();
    test_abort_drain();
    test_abort_sweep();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/combo_meter_fx.md
Name: combo_meter_fx

Overview:
- Registered, parametrised combo meter driving an N-LED thermometer bar from the game's combo count.
- Successor to the 4-bit combinational combo bar. Adds a clamped arbitrary-width count, a celebration sweep when max combo is reached, and a stepped drain animation when a combo breaks.
- Sits between the game scoring logic and the board LED pins. Single clock domain.

Parameters:
- N_LEDS, 16: number of LEDs in the bar; range 2..32.
- CW, 5: width of the combo input.
- MAX_COMBO, 16: combo value that triggers the sweep; 1..2^CW-1.
- STEP_CYCLES, 2500000: clock cycles per animation step, ≥1 (25 ms at 100 MHz).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- combo, input, CW: current combo count, sampled every clk edge.
- led, output, N_LEDS: bar output, registered; bit 0 is the first LED lit.
- busy, output, 1: high while an animation (SWEEP or DRAIN) runs.

Behaviour:
- Reset (rst high at clk edge): led=0, busy=0, state=BAR, lit=0, pos=0, prev_combo=0, step counter=0. Reset mid-animation aborts it immediately.
- target = min(combo, N_LEDS). thermo(k) sets bits [k-1:0], all others 0; thermo(0)=0.
- lit, pos: width clog2(N_LEDS+1).
- prev_combo: registered copy of combo, updated every cycle.
- tick: asserted when step counter == STEP_CYCLES-1; counter then wraps to 0. Counter runs only in SWEEP/DRAIN and clears on every state entry.
- led always equals thermo(lit) registered. Latency is 1 cycle from combo to led in BAR.
- busy = (state != BAR), registered alongside led.

BAR:
- lit <= target every cycle.
- If combo ≥ MAX_COMBO and prev_combo < MAX_COMBO (rising crossing): go SWEEP, pos <= 0, lit <= 0.
- Else if combo == 0 and prev_combo != 0 (break): go DRAIN; lit holds its current value.
- Sweep check has priority.

SWEEP:
- lit <= pos. On tick, pos increments. The tick after pos == N_LEDS returns to BAR, so the full bar is held one step.
- Total length is (N_LEDS+1)*STEP_CYCLES cycles.
- Nonzero combo changes are ignored.
- combo == 0 aborts to DRAIN with lit = pos.

DRAIN:
- On tick, if lit > target then lit decrements by 1.
- When lit == target, go BAR on the same edge.
- If target ≥ lit at any cycle (combo rose), go BAR immediately with lit <= target.
- A rising crossing of MAX_COMBO during DRAIN goes to SWEEP with pos=0.

Arithmetic:
- combo values above N_LEDS clamp to the full bar.
- No wrap on lit or pos. pos saturates at N_LEDS; lit floors at 0.

Optional Feature:
- Macro: COMBO_METER_BLINK_EN.
- Defined:
  - In BAR, while target == N_LEDS, led toggles between all-ones and all-zeros every 4*STEP_CYCLES cycles, starting all-ones on entry to the full condition.
  - A dedicated blink counter resets to 0 whenever the condition is false.
  - busy stays 0.
- Undefined: the full bar is steady. No blink counter is synthesised.

Test Plan:
Benches override STEP_CYCLES=4; all other parameters at default unless stated.
1. Reset/basic bar: assert rst, then combo=5 → led=16'h001F one cycle later, busy=0. Then combo=3 (nonzero drop, no drain) → led=16'h0007 next cycle.
2. Clamp: CW=5, combo=31 with prev ≥16 (no crossing, e.g. 17→31) → led=16'hFFFF steady, busy=0.
3. Sweep: combo 15→16 → busy=1. led steps 0x0000, 0x0001, …, 0xFFFF, each held 4 cycles (68 cycles total), then returns to BAR with led=16'hFFFF and busy=0.
4. Break drain: combo 12→0 → led drops one LED per 4 cycles from 0x0FFF to 0x0000 (48 cycles). busy falls on the edge where lit reaches 0.
5. Abort/resume: during drain at lit=6, set combo=9 → next cycle led=16'h01FF, busy=0. Separately, combo=0 mid-sweep at pos=10 → drain from 0x03FF.
6. Reset mid-sweep: rst high at pos=7 → next cycle led=0, busy=0, and no sweep resumes after rst is released with combo=16 (prev_combo=0 → crossing detected, a new sweep starts from pos 0).
Blink variant (COMBO_METER_BLINK_EN defined): combo=16 held in BAR → led alternates 0xFFFF/0x0000 every 16 cycles.
